// File: rtl/aes_word_source_pkg.sv
// Shared types and constants for the AES word-serial read responder.
package aes_word_source_pkg;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_ISSUE = 2'd1,
    SRC_DRAIN = 2'd2,
    SRC_DONE  = 2'd3
  } aes_source_state_t;

  // Byte stride between consecutive 32-bit words on the TCDM port
  localparam int unsigned AES_WORD_BYTES = 4;

  // Reverse byte order of a word: {b3,b2,b1,b0} -> {b0,b1,b2,b3}
  function automatic logic [31:0] aes_byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_word_source_fifo.sv
// Response buffer for aes_word_source: small power-of-two FIFO with a
// registered head, occupancy count and synchronous flush.
module aes_source_fifo
  import aes_word_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             push_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic                             pop_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [$clog2(FIFO_DEPTH):0]      count_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  push_eff, pop_eff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared at reset so the idle head reads as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_eff && !clear) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

`ifndef SYNTHESIS
  // Credit accounting upstream must never overflow the buffer
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && full_o && !pop_i && !clear))
    else $error("aes_source_fifo overflow");
`endif

endmodule

// File: rtl/aes_word_source.sv
// Word-serial TCDM read responder feeding the AES engine stream.
// Optional feature: define AES_SOURCE_BYTESWAP_EN to byte-reverse data_o.
module aes_word_source
  import aes_word_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  req_start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  trans_size_i,
  output logic                  ready_start_o,
  output logic                  done_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [3:0]            tcdm_be_o,
  input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  aes_source_state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  discard_q;

  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW:0]           occupancy;
  logic                  grant, push, pop;

  // Responses already requested plus words buffered bound the credit window
  assign occupancy  = (CW+1)'(inflight_q) + (CW+1)'(fifo_count);
  assign tcdm_req_o = (state_q == SRC_ISSUE) && (remaining_q != '0) && (occupancy < DEPTH_L);
  assign tcdm_add_o = addr_q;
  assign tcdm_wen_o = 1'b1;
  assign tcdm_be_o  = 4'hF;
  assign grant      = tcdm_req_o && tcdm_gnt_i;
  // A response landing in the cycle after a clear belongs to the flushed transaction
  assign push       = tcdm_r_valid_i && !discard_q && !clear;
  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && ready_i;

  assign ready_start_o = (state_q == SRC_IDLE);
  assign done_o        = (state_q == SRC_DONE);

`ifdef AES_SOURCE_BYTESWAP_EN
  assign data_o = aes_byte_swap(fifo_head);
`else
  assign data_o = fifo_head;
`endif

  aes_source_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push_i  (push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next state, address and remaining-word count
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      SRC_IDLE: begin
        if (req_start_i) begin
          addr_d      = base_addr_i;
          remaining_d = trans_size_i;
          state_d     = (trans_size_i == '0) ? SRC_DONE : SRC_ISSUE;
        end
      end
      SRC_ISSUE: begin
        if (grant) begin
          addr_d      = addr_q + ADDR_WIDTH'(AES_WORD_BYTES);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) state_d = SRC_DRAIN;
        end
      end
      SRC_DRAIN: begin
        // Leave on the cycle of the last pop so done follows it by one cycle
        if (inflight_q == '0 && (fifo_empty || (fifo_count == CW'(1) && pop)))
          state_d = SRC_DONE;
      end
      SRC_DONE: state_d = SRC_IDLE;
      default:  state_d = SRC_IDLE;
    endcase
    if (clear) begin
      state_d     = SRC_IDLE;
      addr_d      = '0;
      remaining_d = '0;
    end
  end

  // Outstanding-response counter
  always_comb begin
    inflight_d = inflight_q;
    case ({grant, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (clear) inflight_d = '0;
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SRC_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      discard_q   <= clear;
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_aes_word_source.sv
// Self-checking bench for aes_word_source (TCDM responder model + stream scoreboard).
module tb_aes_word_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        req_start_i;
  logic [31:0] base_addr_i;
  logic [15:0] trans_size_i;
  logic        ready_start_o;
  logic        done_o;
  logic        tcdm_req_o;
  logic        tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_r_data_i;
  logic        tcdm_r_valid_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  always #5 clk = ~clk;

  aes_word_source #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .CNT_WIDTH  (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .req_start_i    (req_start_i),
    .base_addr_i    (base_addr_i),
    .trans_size_i   (trans_size_i),
    .ready_start_o  (ready_start_o),
    .done_o         (done_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int          cyc = 0;
  int          gnt_mode = 0;      // 0 never, 1 always, 2 random
  logic        ready_en = 1'b0;
  logic        ready_rand = 1'b0;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_data = '0;
  int          accept_cyc, first_req_cyc, first_grant_cyc, first_valid_cyc;
  int          last_pop_cyc, done_cyc;
  int          n_grant, n_pop, n_req_cycles, done_cnt;
  logic [31:0] last_pop_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h0011_2233;
    return (a ^ 32'hC3A5_0000) + 32'h0000_1111;
  endfunction

  function automatic logic [31:0] stream_view(input logic [31:0] w);
`ifdef AES_SOURCE_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // One clock cycle: drive memory/stream inputs at negedge and observe handshakes
  task automatic step();
    @(negedge clk);
    cyc++;
    tcdm_r_valid_i = pend_valid;
    tcdm_r_data_i  = pend_valid ? pend_data : 32'hDEAD_BEEF;
    pend_valid     = 1'b0;
    case (gnt_mode)
      0:       tcdm_gnt_i = 1'b0;
      1:       tcdm_gnt_i = 1'b1;
      default: tcdm_gnt_i = 1'($urandom_range(0, 1));
    endcase
    ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_en;
    if (tcdm_req_o) begin
      n_req_cycles++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (tcdm_req_o && tcdm_gnt_i) begin
      n_grant++;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      if (exp_addr_q.size() == 0) check_val("unexpected_grant", 32'(exp_addr_q.size()), 32'd1);
      else                        check_val("tcdm_add", tcdm_add_o, exp_addr_q.pop_front());
      pend_valid = 1'b1;
      pend_data  = mem_word(tcdm_add_o);
      exp_data_q.push_back(stream_view(pend_data));
    end
    if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (valid_o && ready_i) begin
      n_pop++;
      last_pop_cyc  = cyc;
      last_pop_data = data_o;
      if (exp_data_q.size() == 0) check_val("unexpected_pop", 32'(exp_data_q.size()), 32'd1);
      else                        check_val("stream_data", data_o, exp_data_q.pop_front());
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] size);
    step();
    check_val("ready_start_before_accept", 32'(ready_start_o), 32'd1);
    req_start_i  = 1'b1;
    base_addr_i  = base;
    trans_size_i = size;
    accept_cyc   = cyc;
    first_req_cyc = -1; first_grant_cyc = -1; first_valid_cyc = -1;
    last_pop_cyc = -1; done_cyc = -1;
    n_grant = 0; n_pop = 0; n_req_cycles = 0; done_cnt = 0;
    for (int i = 0; i < int'(size); i++) exp_addr_q.push_back(base + 32'(4 * i));
    step();
    req_start_i  = 1'b0;
    base_addr_i  = 32'hBAD0_0000;
    trans_size_i = 16'h0007;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    check_val({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    check_val({tag, "_ready_low_in_done"}, 32'(ready_start_o), 32'd0);
    step();
    check_val({tag, "_ready_after_done"}, 32'(ready_start_o), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; req_start_i = 1'b0;
    base_addr_i = '0; trans_size_i = '0;
    tcdm_gnt_i = 1'b0; tcdm_r_data_i = '0; tcdm_r_valid_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready_start", 32'(ready_start_o), 32'd1);
    check_val("rst_done",        32'(done_o),        32'd0);
    check_val("rst_tcdm_req",    32'(tcdm_req_o),    32'd0);
    check_val("rst_tcdm_add",    tcdm_add_o,         32'd0);
    check_val("rst_valid",       32'(valid_o),       32'd0);
    check_val("rst_data",        data_o,             32'd0);
    check_val("tcdm_wen_const",  32'(tcdm_wen_o),    32'd1);
    check_val("tcdm_be_const",   32'(tcdm_be_o),     32'hF);
    reset_n = 1'b1;

    // Basic transfer, memory always granting, sink always ready
    gnt_mode = 1; ready_en = 1'b1;
    start(32'h0000_1000, 16'd4);
    wait_done("basic", 100);
    check_val("basic_req_latency",   32'(first_req_cyc - accept_cyc),        32'd1);
    check_val("basic_valid_latency", 32'(first_valid_cyc - first_grant_cyc), 32'd2);
    check_val("basic_done_latency",  32'(done_cyc - last_pop_cyc),           32'd1);
    check_val("basic_grants",        32'(n_grant), 32'd4);
    check_val("basic_pops",          32'(n_pop),   32'd4);
    repeat (3) step();
    check_val("basic_single_done",   32'(done_cnt), 32'd1);

    // Back-pressure: sink stalled for 10 cycles from accept
    ready_en = 1'b0;
    start(32'h0000_1000, 16'd4);
    repeat (9) step();
    check_val("bp_grants_while_stalled", 32'(n_grant), 32'd2);
    check_val("bp_valid_held",           32'(valid_o), 32'd1);
    check_val("bp_head_word",            data_o, stream_view(mem_word(32'h0000_1000)));
    check_val("bp_no_pops",              32'(n_pop),   32'd0);
    ready_en = 1'b1;
    wait_done("bp", 100);
    check_val("bp_pops",      32'(n_pop),   32'd4);
    check_val("bp_grants",    32'(n_grant), 32'd4);
    check_val("bp_sb_empty",  32'(exp_data_q.size()), 32'd0);

    // Zero-length request
    start(32'h0000_1800, 16'd0);
    wait_done("zero", 20);
    check_val("zero_done_latency", 32'(done_cyc - accept_cyc), 32'd1);
    check_val("zero_no_req",       32'(n_req_cycles), 32'd0);

    // Address wrap with random grants
    gnt_mode = 2;
    start(32'hFFFF_FFF8, 16'd4);
    wait_done("wrap", 300);
    check_val("wrap_pops",       32'(n_pop), 32'd4);
    check_val("wrap_addr_empty", 32'(exp_addr_q.size()), 32'd0);

    // Clear after two grants, with a response still due in the following cycle
    gnt_mode = 1; ready_en = 1'b0;
    start(32'h0000_3000, 16'd8);
    for (int k = 0; k < 50 && n_grant < 2; k++) step();
    check_val("clr_two_grants", 32'(n_grant), 32'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    check_val("clr_ready_start", 32'(ready_start_o), 32'd1);
    check_val("clr_valid_low",   32'(valid_o),       32'd0);
    step();
    check_val("clr_rvalid_discarded", 32'(valid_o), 32'd0);
    repeat (6) step();
    check_val("clr_no_done",     32'(done_cnt),   32'd0);
    check_val("clr_idle_no_req", 32'(tcdm_req_o), 32'd0);
    exp_data_q.delete();

    // Recovery after clear and byte-order check
    gnt_mode = 2; ready_en = 1'b1;
    start(32'h0000_2000, 16'd1);
    wait_done("swap", 100);
    check_val("swap_pops", 32'(n_pop), 32'd1);
`ifdef AES_SOURCE_BYTESWAP_EN
    check_val("swap_word", last_pop_data, 32'h3322_1100);
`else
    check_val("swap_word", last_pop_data, 32'h0011_2233);
`endif

    // Random grants and random sink readiness
    ready_rand = 1'b1;
    start(32'h0000_4000, 16'd6);
    wait_done("rand", 400);
    check_val("rand_pops",     32'(n_pop), 32'd6);
    check_val("rand_sb_empty", 32'(exp_data_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
